// File: rtl/feram_nmc_pkg.sv
`default_nettype none
// ============================================================================
// feram_nmc_pkg: sequencer state encoding, block geometry and row-index helper
// Revision: 1.0
// ============================================================================
package feram_nmc_pkg;

  localparam int ROW_BYTES = 4;
  localparam int BLK_ROWS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CAP   = 3'd2,
    ST_OFFER = 3'd3,
    ST_RES   = 3'd4,
    ST_WR    = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // n_rows is a power of two, so the wrap is a mask
  function automatic int unsigned row_idx(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned n_rows);
    return (base + offset) & (n_rows - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/feram_row_gather.sv
`default_nettype none
// ============================================================================
// feram_row_gather: slot-addressed row buffer packed into one block word
// Revision: 1.0
// ============================================================================
module feram_row_gather
  import feram_nmc_pkg::*;
#(
  parameter int ROW_W   = 8 * ROW_BYTES,
  parameter int N_SLOTS = BLK_ROWS,
  localparam int IDX_W  = $clog2(N_SLOTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic [IDX_W-1:0]         slot,
  input  logic [ROW_W-1:0]         row_in,
  output logic [ROW_W*N_SLOTS-1:0] blk_data
);

  logic [N_SLOTS-1:0][ROW_W-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (cap_en) buf_d[slot] = row_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else        buf_q <= buf_d;
  end

  assign blk_data = buf_q;

endmodule
`default_nettype wire

// File: rtl/feram_block_sequencer.sv
`default_nettype none
// ============================================================================
// feram_block_sequencer: walks FeRAM rows, packs 4-row blocks for the core;
// FERAM_WRITEBACK_EN adds result write-back to a destination row range.
// Revision: 1.0
// ============================================================================
module feram_block_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int N_ROWS   = 16,
  parameter int BLK_ROWS = 4,
  localparam int BLK_W   = DATA_W * 4 * BLK_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W-1:0] n_blocks,
  input  logic [ADDR_W-1:0] dst_row,
  output logic              busy,
  output logic              done,
  output logic              mem_sra_en,
  output logic [ADDR_W-1:0] mem_row_addr,
  input  logic [DATA_W*4-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_row,
  output logic [DATA_W*4-1:0] mem_wr_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [BLK_W-1:0]  res_data
);

  import feram_nmc_pkg::*;

  localparam int ROW_W = DATA_W * ROW_BYTES;
  localparam int SUB_W = $clog2(BLK_ROWS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BLK_ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] nblk_q, nblk_d;
  logic [ADDR_W-1:0] blk_idx_q, blk_idx_d;
  logic [SUB_W-1:0]  sub_q, sub_d;

  logic [ADDR_W-1:0] blk_idx_inc;
  logic              blk_more;
  logic [ADDR_W-1:0] rd_row;
  logic              cap_en;
  logic [SUB_W-1:0]  cap_slot;

  assign blk_idx_inc = blk_idx_q + ADDR_W'(1);
  assign blk_more    = blk_idx_inc < nblk_q;
  assign rd_row      = ADDR_W'(row_idx(int'(base_q),
                                       BLK_ROWS * int'(blk_idx_q) + int'(sub_q),
                                       N_ROWS));

`ifdef FERAM_WRITEBACK_EN
  logic [ADDR_W-1:0]                  dst_q, dst_d;
  logic [BLK_ROWS-1:0][ROW_W-1:0]     res_q, res_d;
  logic [ADDR_W-1:0]                  wr_row;

  assign wr_row = ADDR_W'(row_idx(int'(dst_q),
                                  BLK_ROWS * int'(blk_idx_q) + int'(sub_q),
                                  N_ROWS));
`else
  logic unused_wb;
  assign unused_wb = ^{res_valid, res_data, dst_row};
`endif

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    nblk_d       = nblk_q;
    blk_idx_d    = blk_idx_q;
    sub_d        = sub_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_sra_en   = 1'b0;
    mem_row_addr = '0;
    mem_wr_en    = 1'b0;
    mem_wr_row   = '0;
    mem_wr_data  = '0;
    blk_valid    = 1'b0;
    res_ready    = 1'b0;
    cap_en       = 1'b0;
    cap_slot     = '0;
`ifdef FERAM_WRITEBACK_EN
    dst_d        = dst_q;
    res_d        = res_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_row;
          nblk_d    = n_blocks;
          blk_idx_d = '0;
          sub_d     = '0;
`ifdef FERAM_WRITEBACK_EN
          dst_d     = dst_row;
`endif
          state_d   = (n_blocks == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        busy         = 1'b1;
        mem_sra_en   = 1'b1;
        mem_row_addr = rd_row;
        // read data lags the strobe by one cycle, so slot i-1 fills in cycle i
        if (sub_q != '0) begin
          cap_en   = 1'b1;
          cap_slot = sub_q - SUB_W'(1);
        end
        sub_d = sub_q + SUB_W'(1);
        if (sub_q == SUB_LAST) state_d = ST_CAP;
      end
      ST_CAP: begin
        busy     = 1'b1;
        cap_en   = 1'b1;
        cap_slot = SUB_LAST;
        state_d  = ST_OFFER;
      end
      ST_OFFER: begin
        busy      = 1'b1;
        blk_valid = 1'b1;
        if (blk_ready) begin
`ifdef FERAM_WRITEBACK_EN
          state_d   = ST_RES;
`else
          blk_idx_d = blk_idx_inc;
          state_d   = blk_more ? ST_RD : ST_DONE;
`endif
        end
      end
`ifdef FERAM_WRITEBACK_EN
      ST_RES: begin
        busy      = 1'b1;
        res_ready = 1'b1;
        if (res_valid) begin
          res_d   = res_data;
          sub_d   = '0;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_row  = wr_row;
        mem_wr_data = res_q[sub_q];
        sub_d       = sub_q + SUB_W'(1);
        if (sub_q == SUB_LAST) begin
          blk_idx_d = blk_idx_inc;
          state_d   = blk_more ? ST_RD : ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      nblk_q    <= '0;
      blk_idx_q <= '0;
      sub_q     <= '0;
`ifdef FERAM_WRITEBACK_EN
      dst_q     <= '0;
      res_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nblk_q    <= nblk_d;
      blk_idx_q <= blk_idx_d;
      sub_q     <= sub_d;
`ifdef FERAM_WRITEBACK_EN
      dst_q     <= dst_d;
      res_q     <= res_d;
`endif
    end
  end

  feram_row_gather #(
    .ROW_W   (ROW_W),
    .N_SLOTS (BLK_ROWS)
  ) u_gather (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .slot     (cap_slot),
    .row_in   (mem_rd_data),
    .blk_data (blk_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_feram_block_sequencer.sv
`default_nettype none
// ============================================================================
// tb_feram_block_sequencer: directed bench with row-memory model and block
// scoreboard. Revision: 1.0
// ============================================================================
module tb_feram_block_sequencer;

  localparam int ADDR_W = 6;
  localparam int N_ROWS = 16;
`ifdef FERAM_WRITEBACK_EN
  localparam int DONE_LAT = 6;
`else
  localparam int DONE_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_row = '0;
  logic [ADDR_W-1:0] n_blocks = '0;
  logic [ADDR_W-1:0] dst_row = '0;
  logic              busy, done, mem_sra_en, mem_wr_en, blk_valid, res_ready;
  logic [ADDR_W-1:0] mem_row_addr, mem_wr_row;
  logic [31:0]       mem_rd_data = '0;
  logic [31:0]       mem_wr_data;
  logic              blk_ready = 1'b0;
  logic [127:0]      blk_data;
  logic              res_valid = 1'b1;
  logic [127:0]      res_data = '0;

  logic [31:0]       mem [N_ROWS];
  logic [127:0]      sb [$];
  int unsigned       rd_log [$];
  logic [37:0]       wr_log [$];
  logic [127:0]      res_xor = '0;
  int                done_cnt = 0;
  int                n_vec = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  feram_block_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_row     (base_row),
    .n_blocks     (n_blocks),
    .dst_row      (dst_row),
    .busy         (busy),
    .done         (done),
    .mem_sra_en   (mem_sra_en),
    .mem_row_addr (mem_row_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_row   (mem_wr_row),
    .mem_wr_data  (mem_wr_data),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data)
  );

  function automatic logic [31:0] row_word(input int r);
    logic [7:0] b;
    b = 8'(4 * r);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [127:0] exp_block(input int base, input int k);
    logic [127:0] blk;
    for (int i = 0; i < 4; i++) blk[32*i +: 32] = row_word((base + 4*k + i) % N_ROWS);
    return blk;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row memory with a registered read port, plus the core-side echo responder
  always @(posedge clk) begin
    if (mem_sra_en) mem_rd_data <= mem[mem_row_addr[3:0]];
    if (mem_wr_en)  mem[mem_wr_row[3:0]] <= mem_wr_data;
    if (blk_valid && blk_ready) res_data <= blk_data ^ res_xor;
  end

  always @(posedge clk) begin
    if (mem_sra_en) rd_log.push_back(mem_row_addr);
    if (mem_wr_en)  wr_log.push_back({mem_wr_row, mem_wr_data});
    if (done)       done_cnt <= done_cnt + 1;
    if (blk_valid && blk_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL sb_underflow: observed %0h expected none", blk_data);
      end else begin
        check("blk_data", blk_data, sb.pop_front());
      end
    end
  end

  task automatic kick(input int base, input int n, input int dst, input bit push);
    @(negedge clk);
    base_row = ADDR_W'(base);
    n_blocks = ADDR_W'(n);
    dst_row  = ADDR_W'(dst);
    start    = 1'b1;
    if (push) for (int k = 0; k < n; k++) sb.push_back(exp_block(base, k));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!blk_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int d0;
    for (int r = 0; r < N_ROWS; r++) mem[r] = row_word(r);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctl", {busy, done, mem_sra_en, blk_valid, mem_wr_en, res_ready,
                        mem_row_addr, mem_wr_row, mem_wr_data}, '0);
    check("reset_blk", blk_data, '0);
    rst_n = 1'b1;

    // Single block from row 0
    blk_ready = 1'b1;
    kick(0, 1, 0, 1'b1);
    check("A_first_sra", {mem_sra_en, mem_row_addr}, {1'b1, 6'd0});
    wait_valid(cyc);
    check("A_valid_lat", cyc, 6);
    check("A_blk_data", blk_data, 128'h0F0E0D0C0B0A09080706050403020100);
    wait_done(cyc);
    check("A_done_lat", cyc, DONE_LAT);
    check("A_busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("A_done_pulse", done, 1'b0);

    // Back-pressure: block held stable, no reads while stalled
    blk_ready = 1'b0;
    rd_log.delete();
    kick(4, 1, 4, 1'b1);
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("B_stall", {blk_valid, mem_sra_en, blk_data}, {1'b1, 1'b0, exp_block(4, 0)});
    end
    blk_ready = 1'b1;
    wait_done(cyc);
    check("B_done_lat", cyc, DONE_LAT);
    check("B_nreads", rd_log.size(), 4);

    // Wrapping two-block run; a start while busy must be ignored
    rd_log.delete();
    kick(14, 2, 14, 1'b1);
    base_row = 6'd0;
    n_blocks = 6'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("C_done_seen", done, 1'b1);
    check("C_nreads", rd_log.size(), 8);
    for (int i = 0; i < 8; i++) check("C_rd_order", rd_log[i], (14 + i) % N_ROWS);
    repeat (3) @(negedge clk);
    check("C_idle_after", busy, 1'b0);

    // Zero-block run
    rd_log.delete();
    d0 = done_cnt;
    kick(3, 0, 3, 1'b1);
    check("D_done", {done, busy, mem_sra_en}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("D_done_once", done, 1'b0);
    check("D_no_reads", rd_log.size(), 0);
    check("D_done_cnt", done_cnt, d0 + 1);

    // Reset during the reads of the second block, then a clean run
    d0 = done_cnt;
    kick(0, 3, 0, 1'b1);
    wait_valid(cyc);
    @(negedge clk);
    cyc = 0;
    while (!mem_sra_en && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("E_in_rd", {busy, mem_sra_en}, 2'b11);
    #1 rst_n = 1'b0;
    #1 check("E_async_clr", {busy, done, mem_sra_en, blk_valid, mem_wr_en, res_ready,
                             mem_row_addr, blk_data}, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("E_no_done", done_cnt, d0);
    rst_n = 1'b1;
    rd_log.delete();
    kick(8, 2, 8, 1'b1);
    wait_done(cyc);
    check("E_rerun_done", done, 1'b1);
    check("E_rerun_reads", {rd_log.size(), rd_log[0], rd_log[7]}, {32'd8, 32'd8, 32'd15});
    @(negedge clk);

`ifdef FERAM_WRITEBACK_EN
    // Write-back of the inverted block to rows 8..11, then read it back
    wr_log.delete();
    res_xor = '1;
    kick(0, 1, 8, 1'b1);
    wait_done(cyc);
    res_xor = '0;
    check("W_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) check("W_write", wr_log[i], {6'(8 + i), ~row_word(i)});
    @(negedge clk);
    sb.push_back(~exp_block(0, 0));
    kick(8, 1, 8, 1'b0);
    wait_done(cyc);
    check("W_readback_done", done, 1'b1);
    @(negedge clk);
`endif

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/feram_block_sequencer.md
# feram_block_sequencer

Sequencer between the FeRAM row memory and the AES/systolic compute core. It walks a range of memory rows using Single-Row Activation reads and packs every four consecutive 32-bit rows into one 128-bit block. Each block goes to the core over a valid/ready handshake. When write-back is compiled in, it also accepts the core's 128-bit result and writes it back as four rows to a destination range.

## Interface
- ADDR_W, 6, row address width (matches memory)
- DATA_W, 8, byte width; row word = DATA_W*4 = 32 bits
- N_ROWS, 16, rows in memory; must be a power of two; all row addresses wrap modulo N_ROWS
- BLK_ROWS, 4, rows per block; block width BLK_W = DATA_W*4*BLK_ROWS = 128
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- base_row  in  ADDR_W  first source row; sampled with start
- n_blocks  in  ADDR_W  number of blocks in the run; sampled with start
- dst_row  in  ADDR_W  first write-back row; sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- mem_sra_en  out  1  SRA read strobe to memory
- mem_row_addr  out  ADDR_W  read row
- mem_rd_data  in  32  registered memory read word, valid the cycle after mem_sra_en
- mem_wr_en  out  1  row write strobe
- mem_wr_row  out  ADDR_W  write row
- mem_wr_data  out  32  write word
- blk_valid  out  1  block offered to core
- blk_ready  in  1  core accepts block
- blk_data  out  BLK_W  block; row i occupies bits [32*i+31:32*i]
- res_valid  in  1  core result available
- res_ready  out  1  sequencer accepts result
- res_data  in  BLK_W  result block, same row packing as blk_data

## Operation
- States: IDLE, RD, CAP, OFFER, RES, WR, DONE.
- IDLE:
  - start=1 latches base_row, n_blocks and dst_row, and clears blk_idx.
  - If n_blocks=0, go to DONE; otherwise go to RD.
- RD (4 cycles):
  - mem_sra_en=1 with mem_row_addr = (base_row + 4*blk_idx + i) mod N_ROWS, for i = 0..3 on consecutive cycles.
  - Starting in the second RD cycle, capture mem_rd_data into buffer slot i-1.
  - After i=3, go to CAP.
- CAP (1 cycle): no strobe; capture mem_rd_data into slot 3; go to OFFER.
- OFFER:
  - blk_valid=1; blk_data is the buffer and is held stable.
  - On blk_valid&blk_ready: go to RES if write-back is compiled in. Otherwise increment blk_idx, then go to RD if blk_idx < n_blocks, else DONE.
- RES: res_ready=1. On res_valid&res_ready, latch res_data and go to WR.
- WR (4 cycles):
  - mem_wr_en=1, mem_wr_row = (dst_row + 4*blk_idx + i) mod N_ROWS, mem_wr_data = result row i.
  - Then increment blk_idx and go to RD or DONE, using the same rule as OFFER.
- DONE (1 cycle): done=1, then go to IDLE.
- busy=1 in RD, CAP, OFFER, RES and WR.
- start asserted outside IDLE is ignored.
- Reads and writes never occur in the same cycle, so there is no same-row read/write hazard.
- mem_rd_data is ignored outside the RD and CAP capture cycles.
- blk_idx is ADDR_W wide; the comparison with n_blocks is unsigned.

## Timing
- Reset values: all outputs 0, FSM in IDLE, buffers cleared.
- Reset mid-run:
  - Returns to IDLE immediately.
  - A partial block is discarded.
  - Rows already written stay written.
  - done is not pulsed.
- start sampled high at edge E:
  - First mem_sra_en in the cycle after E.
  - blk_valid rises 5 cycles after the first mem_sra_en (6 cycles after E).
- Without write-back: a handshake in cycle h gives the next RD in cycle h+1, so per-block throughput is 6 cycles + OFFER wait.
- With write-back: result accepted in cycle r gives writes in r+1..r+4 and the next RD (or DONE) in r+5.
- Last block: done is high in the cycle after the final handshake (read-only) or after the final write; busy is 0 in that cycle.
- Address wrap: base_row=14 with N_ROWS=16 reads rows 14, 15, 0, 1.

## Configuration
- FERAM_WRITEBACK_EN defined:
  - RES and WR states are present.
  - dst_row is used; res_ready and the mem_wr_* outputs are live.
- FERAM_WRITEBACK_EN undefined:
  - RES and WR states are removed; OFFER advances directly to the next block.
  - res_ready, mem_wr_en, mem_wr_row and mem_wr_data are tied to 0.
  - res_valid, res_data and dst_row are ignored.
  - Ports remain present.

## Structure
- Shared package feram_nmc_pkg holds:
  - the FSM state enumeration
  - ROW_BYTES=4, BLK_ROWS=4
  - the row-index helper (modulo N_ROWS)
- One sub-module, feram_row_gather, holds:
  - the 4-slot row buffer, with capture-enable and slot index as inputs
  - packed output to blk_data

## Test plan
- Rows 0..3 preloaded 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; start with base_row=0, n_blocks=1, blk_ready=1 -> blk_valid 6 cycles after start, blk_data=0x0F0E0D0C0B0A09080706050403020100, done one cycle after handshake.
- blk_ready held 0 for 10 cycles -> blk_valid stays 1, blk_data stable, no mem_sra_en; handshake on release.
- base_row=14, n_blocks=2 -> read order 14, 15, 0, 1, 2, 3, 4, 5; two blocks delivered, then done.
- n_blocks=0 -> done pulse the cycle after start, zero memory strobes.
- FERAM_WRITEBACK_EN: dst_row=8, res_data = block XOR 0xFF.. -> mem_wr_en on 4 cycles to rows 8..11 with the inverted words; subsequent reads of rows 8..11 return those values.
- rst_n pulsed low during RD of block 2 -> all outputs 0 asynchronously, no done; a new start then runs a clean, full sequence.
